iter_divider: RTL and testbench
===============================

// Module: iter_divider
// PURPOSE
//  Multi-cycle radix-2 restoring unsigned divider; the responder side of the execute stage's need/state/cnt divide handshake.
//  Execute drives need plus operand magnitudes and applies sign fix-up itself.
//  The block returns unsigned quotient Q and remainder D.
//  Execute derives ready = (state_o==IDLE & ~need) | (state_o==BUSY & cnt_o==0).
// PARAMETERS
//  XLEN   32  operand/result width
//  CNT_W  6   counter width, >= clog2(XLEN+1)
// PORTS
//  clk_i       in   1      clock; all state updates on rising edge
//  rst         in   1      reset; synchronous, active-high
//  need        in   1      request; sampled only in IDLE
//  Dividend_i  in   XLEN   unsigned dividend, latched at start
//  Divisor_i   in   XLEN   unsigned divisor, latched at start
//  Q           out  XLEN   quotient, registered
//  D           out  XLEN   remainder, registered
//  state_o     out  1      0=IDLE, 1=BUSY
//  cnt_o       out  CNT_W  remaining iterations
// BEHAVIOUR
//  - Reset (rst=1 at edge): state_o=IDLE, cnt_o=0, Q=0, D=0, internal divisor/partial-remainder regs=0.
//    Applies regardless of state; an in-flight divide is discarded.
//  - IDLE & need=1 at edge T (start):
//    divisor_r<=Divisor_i; Q<=Dividend_i (shift reg); D<=0;
//    cnt_o<=XLEN; state_o<=BUSY.
//  - IDLE & need=0: all registers hold; Q/D keep the last result.
//  - BUSY & cnt_o!=0, one iteration per cycle:
//    trial = {D[XLEN-1:0],Q[XLEN-1]} - {1'b0,divisor_r} (XLEN+1 bits).
//    If trial[XLEN]==0: D<=trial[XLEN-1:0]; Q<={Q[XLEN-2:0],1'b1}.
//    Else: D<={D[XLEN-2:0],Q[XLEN-1]}; Q<={Q[XLEN-2:0],1'b0}.
//    Then cnt_o<=cnt_o-1.
//  - BUSY & cnt_o==0 (done cycle): Q/D are final and valid. Next edge: state_o<=IDLE, Q/D hold.
//  - Latency: start at T; done cycle T+1+XLEN (T+33 for XLEN=32); IDLE at T+2+XLEN.
//  - need while BUSY is ignored; operands are not re-sampled.
//    need still high at the first IDLE cycle is a new request and starts a new divide.
//  - Divisor==0: the algorithm yields Q={XLEN{1'b1}} and D=dividend. No special case.
//  - Dividend==0: Q=0, D=0 after the full XLEN iterations.
//  - Width rule: trial is XLEN+1 bits; the borrow bit is never written into D.
// CONFIGURATION
//  DIV_EARLY_OUT_EN defined:
//    At start, if Divisor_i==0: Q<={XLEN{1'b1}}, D<=Dividend_i.
//    Else if Dividend_i<Divisor_i: Q<=0, D<=Dividend_i.
//    In both cases state_o<=BUSY, cnt_o<=0, so the done cycle is T+1.
//    All other operands take the normal XLEN-iteration path.
//  DIV_EARLY_OUT_EN undefined: every divide takes XLEN iterations. Results are bit-identical to the defined case.
// TESTING
//  1. 100/7, need pulse at T -> cnt_o==0 at T+33, Q=14, D=2; state_o IDLE at T+34.
//  2. 0xFFFFFFFF/1 -> Q=0xFFFFFFFF, D=0. 0x80000000/0x80000000 -> Q=1, D=0.
//  3. 0x1234/0 -> Q=0xFFFFFFFF, D=0x1234.
//     With DIV_EARLY_OUT_EN: done at T+1. Without it: done at T+33.
//  4. rst=1 while cnt_o==16 -> next cycle state_o=IDLE, cnt_o=0, Q=0, D=0.
//     Then a new 9/3 divide -> Q=3, D=0.
//  5. Back-to-back: 50/6, then need held into the first IDLE cycle with 77/10
//     -> Q=8,D=2 at the first done; Q=7,D=7 at the second done, 34 cycles later.
//  6. need toggled during BUSY with new operands -> no effect; the original result is returned.

Source files
------------

// File: rtl/iter_divider.sv
// Radix-2 restoring unsigned divider, one quotient bit per cycle, need/state/cnt handshake.
// Optional DIV_EARLY_OUT_EN: finish in one step for divisor==0 or dividend<divisor.
module iter_divider #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk_i,
  input  logic             rst,
  input  logic             need,
  input  logic [XLEN-1:0]  Dividend_i,
  input  logic [XLEN-1:0]  Divisor_i,
  output logic [XLEN-1:0]  Q,
  output logic [XLEN-1:0]  D,
  output logic             state_o,
  output logic [CNT_W-1:0] cnt_o
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t          state;
  logic [XLEN-1:0] divisor_r;
  logic [XLEN:0]   trial;
  logic [XLEN:0]   shifted;

  assign state_o = state;

  // Partial remainder shifted left by one with the next dividend bit, minus divisor.
  always_comb begin
    shifted = {D, Q[XLEN-1]};
    trial   = shifted - {1'b0, divisor_r};
  end

`ifdef DIV_EARLY_OUT_EN
  logic div_zero;
  logic div_small;

  always_comb begin
    div_zero  = (Divisor_i == '0);
    div_small = (Dividend_i < Divisor_i);
  end
`endif

  always_ff @(posedge clk_i) begin
    if (rst) begin
      state     <= IDLE;
      cnt_o     <= '0;
      Q         <= '0;
      D         <= '0;
      divisor_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (need) begin
            divisor_r <= Divisor_i;
            state     <= BUSY;
`ifdef DIV_EARLY_OUT_EN
            if (div_zero) begin
              Q     <= '1;
              D     <= Dividend_i;
              cnt_o <= '0;
            end else if (div_small) begin
              Q     <= '0;
              D     <= Dividend_i;
              cnt_o <= '0;
            end else begin
              Q     <= Dividend_i;
              D     <= '0;
              cnt_o <= CNT_W'(XLEN);
            end
`else
            Q     <= Dividend_i;
            D     <= '0;
            cnt_o <= CNT_W'(XLEN);
`endif
          end
        end
        BUSY: begin
          if (cnt_o != '0) begin
            if (!trial[XLEN]) begin
              D <= trial[XLEN-1:0];
              Q <= {Q[XLEN-2:0], 1'b1};
            end else begin
              D <= shifted[XLEN-1:0];
              Q <= {Q[XLEN-2:0], 1'b0};
            end
            cnt_o <= cnt_o - 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iter_divider.sv
// Self-checking bench for iter_divider: vector table through a scoreboard plus
// hand-written reset, back-to-back and busy-toggle sequences.
module tb_iter_divider;

  localparam int XLEN  = 32;
  localparam int CNT_W = 6;

  logic             clk_i = 1'b0;
  logic             rst;
  logic             need;
  logic [XLEN-1:0]  Dividend_i;
  logic [XLEN-1:0]  Divisor_i;
  logic [XLEN-1:0]  Q;
  logic [XLEN-1:0]  D;
  logic             state_o;
  logic [CNT_W-1:0] cnt_o;

  iter_divider #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk_i      (clk_i),
    .rst        (rst),
    .need       (need),
    .Dividend_i (Dividend_i),
    .Divisor_i  (Divisor_i),
    .Q          (Q),
    .D          (D),
    .state_o    (state_o),
    .cnt_o      (cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] d;
  } vec_t;

  typedef struct {
    logic [31:0] q;
    logic [31:0] d;
    int          t0;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  logic chk_idle = 1'b0;

  always @(posedge clk_i) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_EARLY_OUT_EN
    if (b == 0 || a < b) return 1;
`endif
    return XLEN + 1;
  endfunction

  // Scoreboard consumer: the done cycle is BUSY with cnt_o==0.
  always @(negedge clk_i) begin
    exp_t e;
    if (chk_idle) begin
      check("idle_after_done", 32'(state_o), 32'd0);
      chk_idle = 1'b0;
    end
    if (!rst && state_o && cnt_o == 0) begin
      check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("Q", Q, e.q);
        check("D", D, e.d);
        check("latency", 32'(cyc - e.t0), 32'(e.lat));
      end
      chk_idle = 1'b1;
    end
  end

  task automatic push_exp(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] q, input logic [31:0] d, input int t0);
    exp_t e;
    e.q = q; e.d = d; e.t0 = t0; e.lat = exp_lat(a, b);
    sb.push_back(e);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (state_o !== 1'b0 && n < 100) begin
      @(posedge clk_i); #1; n++;
    end
    if (n >= 100) check("wait_idle_timeout", 32'(state_o), 32'd0);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!(state_o === 1'b1 && cnt_o === '0) && n < 100) begin
      @(posedge clk_i); #1; n++;
    end
    if (n >= 100) check("wait_done_timeout", 32'(cnt_o), 32'd0);
  endtask

  task automatic start(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] q, input logic [31:0] d);
    wait_idle();
    @(posedge clk_i); #1;
    need = 1'b1; Dividend_i = a; Divisor_i = b;
    push_exp(a, b, q, d, cyc);
    @(posedge clk_i); #1;
    need = 1'b0;
  endtask

  vec_t vecs[12];

  initial begin
    logic [31:0] ra, rb;
    int n;

    vecs[0] = '{32'd100,        32'd7,          32'd14,         32'd2};
    vecs[1] = '{32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0};
    vecs[2] = '{32'h8000_0000,  32'h8000_0000,  32'd1,          32'd0};
    vecs[3] = '{32'h0000_1234,  32'd0,          32'hFFFF_FFFF,  32'h1234};
    vecs[4] = '{32'd0,          32'd5,          32'd0,          32'd0};
    vecs[5] = '{32'd5,          32'd9,          32'd0,          32'd5};
    vecs[6] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0};
    vecs[7] = '{32'h1234_5678,  32'd1000,       32'd305419,     32'd896};
    vecs[8] = '{32'd0,          32'd0,          32'hFFFF_FFFF,  32'd0};
    vecs[9] = '{32'hFFFF_FFFE,  32'hFFFF_FFFF,  32'd0,          32'hFFFF_FFFE};
    for (int i = 10; i < 12; i++) begin
      ra = $urandom;
      rb = $urandom_range(1, 65535);
      vecs[i] = '{ra, rb, ra / rb, ra % rb};
    end

    rst = 1'b1; need = 1'b0; Dividend_i = '0; Divisor_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_cnt",   32'(cnt_o),   32'd0);
    check("rst_Q",     Q,            32'd0);
    check("rst_D",     D,            32'd0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      start(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].d);
      wait_done();
    end

    // Results hold while idle with need low.
    repeat (4) @(posedge clk_i);
    #1;
    check("hold_state", 32'(state_o), 32'd0);
    check("hold_Q", Q, vecs[11].q);
    check("hold_D", D, vecs[11].d);

    // Reset in the middle of a divide discards it.
    start(32'hDEAD_BEEF, 32'h1357, 32'd0, 32'd0);
    n = 0;
    while (cnt_o !== 6'd16 && n < 100) begin
      @(posedge clk_i); #1; n++;
    end
    check("reach_cnt16", 32'(cnt_o), 32'd16);
    rst = 1'b1;
    @(posedge clk_i); #1;
    rst = 1'b0;
    sb.delete();
    check("midrst_state", 32'(state_o), 32'd0);
    check("midrst_cnt",   32'(cnt_o),   32'd0);
    check("midrst_Q",     Q,            32'd0);
    check("midrst_D",     D,            32'd0);
    start(32'd9, 32'd3, 32'd3, 32'd0);
    wait_done();

    // Back-to-back: need raised in the done cycle and held into the first IDLE cycle.
    start(32'd50, 32'd6, 32'd8, 32'd2);
    wait_done();
    need = 1'b1; Dividend_i = 32'd77; Divisor_i = 32'd10;
    push_exp(32'd77, 32'd10, 32'd7, 32'd7, cyc + 1);
    @(posedge clk_i); #1;
    check("b2b_idle", 32'(state_o), 32'd0);
    @(posedge clk_i); #1;
    need = 1'b0;
    check("b2b_restart", 32'(state_o), 32'd1);
    wait_done();

    // need and operands wiggling while BUSY must not disturb the divide.
    start(32'd1000, 32'd7, 32'd142, 32'd6);
    n = 0;
    while (cnt_o > 3 && n < 100) begin
      need = 1'($urandom_range(0, 1));
      Dividend_i = $urandom;
      Divisor_i = $urandom;
      @(posedge clk_i); #1; n++;
    end
    need = 1'b0;
    wait_done();

    repeat (3) @(posedge clk_i);
    #1;
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
